bsg_counter_overflow_set_en_multi: RTL and testbench
====================================================

# bsg_counter_overflow_set_en_multi

Parametrised, multi-channel successor to the single fixed-limit overflow counter. Holds `els_p` independent up/down counters of `width_p` bits, each with a runtime wrap limit, load (set), enable, and a sticky overflow flag. When `chain_p=1`, the channels can cascade into one multi-digit counter, for example a prescaler followed by seconds and minutes. It sits in timer and timebase logic wherever the fixed-constant counter was used before.

## Interface
Parameters:
- `els_p`, default 4: number of counter channels, at least 1.
- `width_p`, default 24: counter width per channel, at least 1.
- `chain_p`, default 0: 1 means channel k advances only on channel k-1 carry (cascade); 0 means the channels are independent.

Ports:
- `clk_i`  in  1  single clock. All state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  els_p  per-channel step enable.
- `set_i`  in  els_p  per-channel load of `val_i`. Highest priority.
- `val_i`  in  els_p*width_p  load values, channel k at `[k*width_p +: width_p]`.
- `limit_i`  in  els_p*width_p  per-channel wrap limit. Sampled every cycle.
- `down_i`  in  els_p  per-channel direction: 1 = count down, 0 = count up.
- `clear_sticky_i`  in  els_p  clears `overflow_sticky_o[k]`.
- `count_o`  out  els_p*width_p  registered count.
- `overflow_o`  out  els_p  count is at its terminal value (level, combinational from registers).
- `carry_o`  out  els_p  one-cycle wrap event (combinational).
- `overflow_sticky_o`  out  els_p  registered, latched wrap event.

## Operation
Per-channel definitions:
- **term[k]**: `count == limit` when up; `count == 0` when down.
- **restart[k]**: 0 when up; `limit` when down.
- **step[k]**: `en_i[k] & ~set_i[k] & (chain_p && k>0 ? carry[k-1] : 1)`.
- **carry[k]**: `step[k] & term[k]`.
- **overflow_o[k]**: `term[k]`.
- **carry_o[k]**: `carry[k]`.

Next-count priority, highest first:
- `set_i` loads `val_i`.
- `carry` loads `restart`.
- `step` gives `count ± 1`, modulo 2^width_p.
- Otherwise the count holds.

Differences from the legacy block:
- Wrap is gated by the step enable. A disabled counter sitting at term holds there and `overflow_o` stays high.
- The limit is a runtime input, not a constant.

Arithmetic rules:
- Terminal detection is exact equality only.
- Up count above the limit (after a load or a limit change) continues to all-ones, then wraps to 0. It then reaches the limit normally.
- Down count from 0 wraps to `limit`, not to all-ones.
- `down_i` and `limit_i` take effect in the same cycle they change.

Sticky flag:
- Set by `carry[k]`, cleared by `clear_sticky_i[k]`.
- If both happen in the same cycle, set wins, so no event is lost.

Chaining:
- `set_i[k]` suppresses `carry[k]`, so downstream channels do not advance on a load.
- The carry ripples combinationally through all channels in one cycle.
- `limit=0` gives divide-by-1: when up, every step is a carry.

## Timing
- Reset (asynchronous assert): all `count_o` = 0, `overflow_sticky_o` = 0. `overflow_o` then reflects 0 against `limit_i`, and `carry_o` follows the inputs.
- `count_o` latency is 1 cycle from `set`/`en`.
- `carry_o` and `overflow_o` have 0-cycle latency relative to the registered count and the current inputs.
- `overflow_sticky_o` goes high 1 cycle after `carry_o`.
- Reset asserted mid-count clears state immediately. The first rising edge after deassertion steps from 0.
- Chain critical path: els_p × (width_p compare + AND). It is documented, not pipelined.

## Structure
- No package types are needed. Channel field slicing uses a localparam or function inside the module.
- Sub-module `bsg_counter_overflow_set_en_ch` is a single channel: count register, term detection, next-count mux, sticky flag. It has a `carry_in_i` input, tied high when unchained.
- Top level: a generate loop of `els_p` channels plus the chain wiring.

## Test plan
All scenarios use `width_p=8`.
- **Up wrap, independent channels**: `limit=5`, `en=1` from reset → count 0,1,2,3,4,5,0. `carry_o` is high only in the cycle count=5, and the sticky flag rises the next cycle.
- **Down wrap**: `down=1`, `limit=3`, load `val=1` → count 1,0,3,2,…. `carry_o` is high at 0, and the count reloads 3.
- **Chain**: `chain_p=1`, `els_p=2`, limits 2 and 1, all `en=1` → pairs (ch0,ch1) are (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(0,0). `carry_o[1]` is high only at (2,1).
- **Priority collisions**:
  - set + term + en at count=5 → loads `val=9`, with no carry and no sticky.
  - Sticky clear and carry in the same cycle → sticky stays 1.
  - `en=0` at term → count holds 5 and `overflow_o` stays high.
- **Out-of-range**: load 200 with `limit=5`, up → counts to 255, then 0, then wraps at 5 as normal.
- **Async reset mid-count**: assert `reset_i` between edges at count=4 → `count_o`=0 and sticky=0 immediately, before the next edge.

Source files
------------

// File: rtl/bsg_counter_overflow_set_en_multi_pkg.sv
// Shared definitions for the multi-channel overflow counter.
// Contents:
//   dir_e          - count direction as seen on a channel's down_i bit
//   ELS_DEFAULT    - default number of channels
//   WIDTH_DEFAULT  - default per-channel counter width
package bsg_counter_overflow_set_en_multi_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int ELS_DEFAULT   = 4;
  localparam int WIDTH_DEFAULT = 24;

endpackage

// File: rtl/bsg_counter_overflow_set_en_multi_if.sv
// Bundle of the per-channel control and status buses of the counter.
// Channel k occupies bit k of the 1-bit-per-channel buses and
// [k*width_p +: width_p] of the wide buses.
//   master: drives en_i, set_i, val_i, limit_i, down_i, clear_sticky_i
//           and observes count_o, overflow_o, carry_o, overflow_sticky_o
//   slave : the counter itself
interface bsg_counter_overflow_set_en_multi_if #(
  parameter int els_p   = 4,
  parameter int width_p = 24
);
  logic [els_p-1:0]         en_i;
  logic [els_p-1:0]         set_i;
  logic [els_p*width_p-1:0] val_i;
  logic [els_p*width_p-1:0] limit_i;
  logic [els_p-1:0]         down_i;
  logic [els_p-1:0]         clear_sticky_i;
  logic [els_p*width_p-1:0] count_o;
  logic [els_p-1:0]         overflow_o;
  logic [els_p-1:0]         carry_o;
  logic [els_p-1:0]         overflow_sticky_o;

  modport master (
    output en_i, set_i, val_i, limit_i, down_i, clear_sticky_i,
    input  count_o, overflow_o, carry_o, overflow_sticky_o
  );

  modport slave (
    input  en_i, set_i, val_i, limit_i, down_i, clear_sticky_i,
    output count_o, overflow_o, carry_o, overflow_sticky_o
  );
endinterface

// File: rtl/bsg_counter_overflow_set_en_ch.sv
// One counter channel: count register, terminal detection, next-count
// selection and a sticky wrap flag.
// Ports:
//   clk_i, reset_i     - clock, asynchronous active-high reset
//   en_i               - step enable
//   set_i              - load val_i (wins over everything else)
//   carry_in_i         - upstream carry; tie high for a free-running channel
//   down_i             - 1 counts down, 0 counts up
//   clear_sticky_i     - clears overflow_sticky_o
//   val_i, limit_i     - load value and runtime wrap limit
//   count_o            - registered count
//   overflow_o         - count is at its terminal value
//   carry_o            - wrap happens on the coming edge
//   overflow_sticky_o  - latched wrap event
module bsg_counter_overflow_set_en_ch
  import bsg_counter_overflow_set_en_multi_pkg::*;
#(
  parameter int width_p = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               set_i,
  input  logic               carry_in_i,
  input  logic               down_i,
  input  logic               clear_sticky_i,
  input  logic [width_p-1:0] val_i,
  input  logic [width_p-1:0] limit_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o,
  output logic               carry_o,
  output logic               overflow_sticky_o
);

  localparam logic [width_p-1:0] One = width_p'(1);

  dir_e               dir;
  logic [width_p-1:0] count_r, count_n, restart;
  logic               term, step, carry;
  logic               sticky_r, sticky_n;

  assign dir = dir_e'(down_i);

  // Terminal value is exact equality, so an up count loaded above the
  // limit runs on to all-ones and wraps through zero naturally.
  assign term    = (dir == DIR_DOWN) ? (count_r == '0) : (count_r == limit_i);
  assign restart = (dir == DIR_DOWN) ? limit_i : '0;

  // A load blocks the step, which also keeps downstream channels still.
  assign step  = en_i & ~set_i & carry_in_i;
  assign carry = step & term;

  always_comb begin
    count_n = count_r;
    if (set_i) begin
      count_n = val_i;
    end else if (carry) begin
      count_n = restart;
    end else if (step) begin
      count_n = (dir == DIR_DOWN) ? (count_r - One) : (count_r + One);
    end
  end

  // A wrap in the same cycle as a clear keeps the flag set.
  assign sticky_n = carry | (sticky_r & ~clear_sticky_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r  <= '0;
      sticky_r <= 1'b0;
    end else begin
      count_r  <= count_n;
      sticky_r <= sticky_n;
    end
  end

  assign count_o           = count_r;
  assign overflow_o        = term;
  assign carry_o           = carry;
  assign overflow_sticky_o = sticky_r;

endmodule

// File: rtl/bsg_counter_overflow_set_en_multi.sv
// Bank of els_p up/down counters with runtime wrap limits, loads, enables
// and sticky wrap flags. With chain_p=1 channel k only steps on channel
// k-1's carry, forming one multi-digit counter; the carry ripples through
// every channel combinationally in a single cycle.
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset
//   bus      - slave side of the control/status interface
module bsg_counter_overflow_set_en_multi
  import bsg_counter_overflow_set_en_multi_pkg::*;
#(
  parameter int els_p   = ELS_DEFAULT,
  parameter int width_p = WIDTH_DEFAULT,
  parameter int chain_p = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  bsg_counter_overflow_set_en_multi_if.slave    bus
);

  logic [els_p-1:0]         carry_w;
  logic [els_p-1:0]         overflow_w;
  logic [els_p-1:0]         sticky_w;
  logic [els_p*width_p-1:0] count_w;

  for (genvar k = 0; k < els_p; k++) begin : g_ch
    localparam int Lo = k * width_p;

    logic carry_in;
    logic carry;

    // The chain hops through each block's own carry rather than a shared
    // vector so the ripple is not seen as a loop within one signal.
    if (chain_p != 0 && k > 0) begin : g_chain
      assign carry_in = g_ch[k-1].carry;
    end else begin : g_free
      assign carry_in = 1'b1;
    end

    bsg_counter_overflow_set_en_ch #(
      .width_p(width_p)
    ) ch (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .en_i              (bus.en_i[k]),
      .set_i             (bus.set_i[k]),
      .carry_in_i        (carry_in),
      .down_i            (bus.down_i[k]),
      .clear_sticky_i    (bus.clear_sticky_i[k]),
      .val_i             (bus.val_i[Lo +: width_p]),
      .limit_i           (bus.limit_i[Lo +: width_p]),
      .count_o           (count_w[Lo +: width_p]),
      .overflow_o        (overflow_w[k]),
      .carry_o           (carry),
      .overflow_sticky_o (sticky_w[k])
    );

    assign carry_w[k] = carry;
  end

  assign bus.count_o           = count_w;
  assign bus.overflow_o        = overflow_w;
  assign bus.carry_o           = carry_w;
  assign bus.overflow_sticky_o = sticky_w;

endmodule

// File: tb/tb_bsg_counter_overflow_set_en_multi.sv
// Self-checking bench for bsg_counter_overflow_set_en_multi (width 8).
// dutA: 4 independent channels. dutB: 2 chained channels.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_bsg_counter_overflow_set_en_multi;

  typedef struct {
    logic       en;
    logic       set;
    logic [7:0] val;
    logic [7:0] lim;
    logic       down;
    logic       clr;
    logic [7:0] expCount;
    logic       expCarry;
    logic       expOvf;
    logic       expSticky;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_counter_overflow_set_en_multi_if #(.els_p(4), .width_p(8)) ifA ();
  bsg_counter_overflow_set_en_multi_if #(.els_p(2), .width_p(8)) ifB ();

  bsg_counter_overflow_set_en_multi #(.els_p(4), .width_p(8), .chain_p(0)) dutA (
    .clk_i(clk), .reset_i(rst), .bus(ifA)
  );
  bsg_counter_overflow_set_en_multi #(.els_p(2), .width_p(8), .chain_p(1)) dutB (
    .clk_i(clk), .reset_i(rst), .bus(ifB)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive channel 0 of dutA on the falling edge, then settle.
  task automatic driveA0(input logic en, input logic set, input logic [7:0] val,
                         input logic [7:0] lim, input logic down, input logic clr);
    @(negedge clk);
    ifA.en_i[0]           = en;
    ifA.set_i[0]          = set;
    ifA.val_i[7:0]        = val;
    ifA.limit_i[7:0]      = lim;
    ifA.down_i[0]         = down;
    ifA.clear_sticky_i[0] = clr;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveA0(v.en, v.set, v.val, v.lim, v.down, v.clr);
  endtask

  function automatic vec_t mkVec(input logic en, input logic set, input logic [7:0] val,
                                 input logic clr, input logic [7:0] cnt, input logic c,
                                 input logic o, input logic s);
    vec_t v;
    v.en = en; v.set = set; v.val = val; v.lim = 8'd5; v.down = 1'b0; v.clr = clr;
    v.expCount = cnt; v.expCarry = c; v.expOvf = o; v.expSticky = s;
    return v;
  endfunction

  // Reference model: one evaluation of a bank of channels from the
  // counting rules, with the cascade expressed as a left-to-right scan.
  function automatic void modelEval(input int n, input bit chained, input int cnt[4],
                                    input bit en[4], input bit set[4], input bit down[4],
                                    input int val[4], input int lim[4],
                                    output int nxt[4], output bit term[4], output bit carry[4]);
    bit prevCarry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt[k] = 0; term[k] = 1'b0; carry[k] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      bit step;
      term[k]  = down[k] ? (cnt[k] == 0) : (cnt[k] == lim[k]);
      step     = en[k] && !set[k] && (!chained || prevCarry);
      carry[k] = step && term[k];
      if (set[k])       nxt[k] = val[k];
      else if (!step)   nxt[k] = cnt[k];
      else if (down[k]) nxt[k] = (cnt[k] == 0) ? lim[k] : cnt[k] - 1;
      else              nxt[k] = (cnt[k] == lim[k]) ? 0 : (cnt[k] + 1) % 256;
      prevCarry = carry[k];
    end
  endfunction

  task automatic randPick(inout int lim[4], inout bit dn[4], output bit en[4],
                          output bit set[4], output bit clr[4], output int val[4]);
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 31) == 0)
        lim[k] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) dn[k] = ~dn[k];
      en[k]  = ($urandom_range(0, 3) != 0);
      set[k] = ($urandom_range(0, 15) == 0);
      clr[k] = ($urandom_range(0, 7) == 0);
      val[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 7));
    end
  endtask

  initial begin
    int chain0[7] = '{0, 1, 2, 0, 1, 2, 0};
    int chain1[7] = '{0, 0, 0, 1, 1, 1, 0};
    int downCnt[4] = '{1, 0, 3, 2};
    int cntA[4], cntB[4], nxt[4], valA[4], valB[4], limA[4], limB[4];
    bit stA[4], stB[4], dnA[4], dnB[4], enA[4], enB[4], setA[4], setB[4];
    bit clrA[4], clrB[4], term[4], carry[4];
    logic [31:0] expCnt;
    logic [3:0]  expOvf, expCar, expSt;

    vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(1, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mkVec(1, 0, 0, 0, 2, 0, 0, 0);
    vecs[3]  = mkVec(1, 0, 0, 0, 3, 0, 0, 0);
    vecs[4]  = mkVec(1, 0, 0, 0, 4, 0, 0, 0);
    vecs[5]  = mkVec(1, 0, 0, 0, 5, 1, 1, 0);
    vecs[6]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mkVec(1, 0, 0, 1, 1, 0, 0, 1);
    vecs[8]  = mkVec(1, 0, 0, 0, 2, 0, 0, 0);
    vecs[9]  = mkVec(1, 0, 0, 0, 3, 0, 0, 0);
    vecs[10] = mkVec(1, 0, 0, 0, 4, 0, 0, 0);
    vecs[11] = mkVec(1, 1, 9, 0, 5, 0, 1, 0);
    vecs[12] = mkVec(1, 1, 5, 0, 9, 0, 0, 0);
    vecs[13] = mkVec(1, 0, 0, 1, 5, 1, 1, 0);
    vecs[14] = mkVec(1, 1, 5, 0, 0, 0, 0, 1);
    vecs[15] = mkVec(0, 0, 0, 0, 5, 0, 1, 1);
    vecs[16] = mkVec(0, 0, 0, 0, 5, 0, 1, 1);

    rst = 1'b1;
    ifA.en_i = '0; ifA.set_i = '0; ifA.val_i = '0; ifA.limit_i = {4{8'd5}};
    ifA.down_i = '0; ifA.clear_sticky_i = '0;
    ifB.en_i = '0; ifB.set_i = '0; ifB.val_i = '0; ifB.limit_i = '0;
    ifB.down_i = '0; ifB.clear_sticky_i = '0;

    // Reset state; with limit 0 an idle up channel sits at its terminal value.
    @(negedge clk);
    #1;
    checkOutput("reset countA", 64'(ifA.count_o), 64'h0);
    checkOutput("reset stickyA", 64'(ifA.overflow_sticky_o), 64'h0);
    checkOutput("reset ovfA lim5", 64'(ifA.overflow_o), 64'h0);
    checkOutput("reset ovfB lim0", 64'(ifB.overflow_o), 64'h3);
    checkOutput("reset carryB en0", 64'(ifB.carry_o), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d count", i), 64'(ifA.count_o[7:0]), 64'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d carry", i), 64'(ifA.carry_o[0]), 64'(vecs[i].expCarry));
      checkOutput($sformatf("vec%0d ovf", i), 64'(ifA.overflow_o[0]), 64'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d sticky", i), 64'(ifA.overflow_sticky_o[0]), 64'(vecs[i].expSticky));
    end

    // Chained pair: limits 2 and 1, both enabled.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ifB.limit_i = {8'd1, 8'd2};
      ifB.en_i    = 2'b11;
      #1;
      checkOutput($sformatf("chain%0d ch0", i), 64'(ifB.count_o[7:0]), 64'(chain0[i]));
      checkOutput($sformatf("chain%0d ch1", i), 64'(ifB.count_o[15:8]), 64'(chain1[i]));
      checkOutput($sformatf("chain%0d carry1", i), 64'(ifB.carry_o[1]), 64'(i == 5));
    end

    // Down wrap from a load of 1 with limit 3.
    driveA0(0, 1, 8'd1, 8'd3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      driveA0(1, 0, 8'd0, 8'd3, 1, 0);
      checkOutput($sformatf("down%0d count", i), 64'(ifA.count_o[7:0]), 64'(downCnt[i]));
      checkOutput($sformatf("down%0d carry", i), 64'(ifA.carry_o[0]), 64'(i == 1));
    end

    // Up count loaded above the limit: runs to 255, wraps to 0, then at 5.
    driveA0(1, 1, 8'd200, 8'd5, 0, 0);
    for (int i = 0; i < 63; i++) begin
      int e;
      driveA0(1, 0, 8'd0, 8'd5, 0, 0);
      e = (i < 56) ? 200 + i : (i - 56) % 6;
      checkOutput($sformatf("oor%0d count", i), 64'(ifA.count_o[7:0]), 64'(e));
      checkOutput($sformatf("oor%0d carry", i), 64'(ifA.carry_o[0]), 64'(i == 61));
    end

    // Reset asserted between edges while counting at 4.
    driveA0(1, 1, 8'd4, 8'd5, 0, 0);
    ifB.en_i = 2'b00;
    driveA0(1, 0, 8'd0, 8'd5, 0, 0);
    checkOutput("prereset count", 64'(ifA.count_o[7:0]), 64'd4);
    checkOutput("prereset sticky", 64'(ifA.overflow_sticky_o[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset countA", 64'(ifA.count_o), 64'h0);
    checkOutput("async reset stickyA", 64'(ifA.overflow_sticky_o), 64'h0);
    checkOutput("async reset countB", 64'(ifB.count_o), 64'h0);
    #1 rst = 1'b0;
    driveA0(0, 0, 8'd0, 8'd5, 0, 0);
    checkOutput("post reset step", 64'(ifA.count_o[7:0]), 64'd1);

    // Randomised phase against the reference model.
    cntA = '{1, 0, 0, 0}; cntB = '{0, 0, 0, 0};
    stA = '{0, 0, 0, 0};  stB = '{0, 0, 0, 0};
    dnA = '{0, 0, 0, 0};  dnB = '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      limA[k] = int'($urandom_range(1, 6));
      limB[k] = int'($urandom_range(0, 3));
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      randPick(limA, dnA, enA, setA, clrA, valA);
      randPick(limB, dnB, enB, setB, clrB, valB);
      for (int k = 0; k < 4; k++) begin
        ifA.en_i[k] = enA[k]; ifA.set_i[k] = setA[k]; ifA.down_i[k] = dnA[k];
        ifA.clear_sticky_i[k] = clrA[k];
        ifA.val_i[k*8 +: 8] = 8'(valA[k]); ifA.limit_i[k*8 +: 8] = 8'(limA[k]);
      end
      for (int k = 0; k < 2; k++) begin
        ifB.en_i[k] = enB[k]; ifB.set_i[k] = setB[k]; ifB.down_i[k] = dnB[k];
        ifB.clear_sticky_i[k] = clrB[k];
        ifB.val_i[k*8 +: 8] = 8'(valB[k]); ifB.limit_i[k*8 +: 8] = 8'(limB[k]);
      end
      #1;

      modelEval(4, 1'b0, cntA, enA, setA, dnA, valA, limA, nxt, term, carry);
      expCnt = '0; expOvf = '0; expCar = '0; expSt = '0;
      for (int k = 0; k < 4; k++) begin
        expCnt[k*8 +: 8] = 8'(cntA[k]);
        expOvf[k] = term[k]; expCar[k] = carry[k]; expSt[k] = stA[k];
      end
      checkOutput("randA count", 64'(ifA.count_o), 64'(expCnt));
      checkOutput("randA ovf", 64'(ifA.overflow_o), 64'(expOvf));
      checkOutput("randA carry", 64'(ifA.carry_o), 64'(expCar));
      checkOutput("randA sticky", 64'(ifA.overflow_sticky_o), 64'(expSt));
      for (int k = 0; k < 4; k++) begin
        cntA[k] = nxt[k];
        stA[k]  = carry[k] | (stA[k] & ~clrA[k]);
      end

      modelEval(2, 1'b1, cntB, enB, setB, dnB, valB, limB, nxt, term, carry);
      expCnt = '0; expOvf = '0; expCar = '0; expSt = '0;
      for (int k = 0; k < 2; k++) begin
        expCnt[k*8 +: 8] = 8'(cntB[k]);
        expOvf[k] = term[k]; expCar[k] = carry[k]; expSt[k] = stB[k];
      end
      checkOutput("randB count", 64'(ifB.count_o), 64'(expCnt[15:0]));
      checkOutput("randB ovf", 64'(ifB.overflow_o), 64'(expOvf[1:0]));
      checkOutput("randB carry", 64'(ifB.carry_o), 64'(expCar[1:0]));
      checkOutput("randB sticky", 64'(ifB.overflow_sticky_o), 64'(expSt[1:0]));
      for (int k = 0; k < 2; k++) begin
        cntB[k] = nxt[k];
        stB[k]  = carry[k] | (stB[k] & ~clrB[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
